morse_encoder: RTL and testbench

MORSE_ENCODER -- requirements
Module: morse_encoder

---
 rtl/morse_encoder.sv | 174 +++++++++++++++++
 tb/tb_morse_encoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder.sv
// Morse keyer: accepts one ASCII character per handshake and keys an active-low LED
// with ITU timing (dot 1, dash 3, element gap 1, char gap 3, word gap 7 units).
module morse_encoder #(
    parameter int unsigned UNIT_TICKS = 24'h493e00
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_led_n,
    output logic       o_busy,
    output logic       o_err
);

    // Handshake: a character transfers on a rising edge where i_valid && o_ready;
    // o_ready is high only in IDLE, and i_valid is ignored otherwise (no buffering).

    localparam int TW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(UNIT_TICKS - 1);

    typedef enum logic [2:0] {IDLE, MARK, SPACE, CGAP, WGAP} state_t;

    state_t        state, state_d;
    logic [TW-1:0] tick, tick_d;
    logic [2:0]    unit, unit_d, unit_last;
    logic [4:0]    code, code_d;
    logic [2:0]    remain, remain_d;
    logic          led_d, err_d;
    logic [7:0]    upper;
    logic [2:0]    lk_len;
    logic [4:0]    lk_pat;
    logic          take, tick_done, unit_done;

    // Code table: element count plus left-aligned pattern, 1 = dash.
    always_comb begin
        upper = ((i_data >= "a") && (i_data <= "z")) ? (i_data - 8'd32) : i_data;
        case (upper)
            "A": {lk_len, lk_pat} = {3'd2, 5'b01000};
            "B": {lk_len, lk_pat} = {3'd4, 5'b10000};
            "C": {lk_len, lk_pat} = {3'd4, 5'b10100};
            "D": {lk_len, lk_pat} = {3'd3, 5'b10000};
            "E": {lk_len, lk_pat} = {3'd1, 5'b00000};
            "F": {lk_len, lk_pat} = {3'd4, 5'b00100};
            "G": {lk_len, lk_pat} = {3'd3, 5'b11000};
            "H": {lk_len, lk_pat} = {3'd4, 5'b00000};
            "I": {lk_len, lk_pat} = {3'd2, 5'b00000};
            "J": {lk_len, lk_pat} = {3'd4, 5'b01110};
            "K": {lk_len, lk_pat} = {3'd3, 5'b10100};
            "L": {lk_len, lk_pat} = {3'd4, 5'b01000};
            "M": {lk_len, lk_pat} = {3'd2, 5'b11000};
            "N": {lk_len, lk_pat} = {3'd2, 5'b10000};
            "O": {lk_len, lk_pat} = {3'd3, 5'b11100};
            "P": {lk_len, lk_pat} = {3'd4, 5'b01100};
            "Q": {lk_len, lk_pat} = {3'd4, 5'b11010};
            "R": {lk_len, lk_pat} = {3'd3, 5'b01000};
            "S": {lk_len, lk_pat} = {3'd3, 5'b00000};
            "T": {lk_len, lk_pat} = {3'd1, 5'b10000};
            "U": {lk_len, lk_pat} = {3'd3, 5'b00100};
            "V": {lk_len, lk_pat} = {3'd4, 5'b00010};
            "W": {lk_len, lk_pat} = {3'd3, 5'b01100};
            "X": {lk_len, lk_pat} = {3'd4, 5'b10010};
            "Y": {lk_len, lk_pat} = {3'd4, 5'b10110};
            "Z": {lk_len, lk_pat} = {3'd4, 5'b11000};
            "0": {lk_len, lk_pat} = {3'd5, 5'b11111};
            "1": {lk_len, lk_pat} = {3'd5, 5'b01111};
            "2": {lk_len, lk_pat} = {3'd5, 5'b00111};
            "3": {lk_len, lk_pat} = {3'd5, 5'b00011};
            "4": {lk_len, lk_pat} = {3'd5, 5'b00001};
            "5": {lk_len, lk_pat} = {3'd5, 5'b00000};
            "6": {lk_len, lk_pat} = {3'd5, 5'b10000};
            "7": {lk_len, lk_pat} = {3'd5, 5'b11000};
            "8": {lk_len, lk_pat} = {3'd5, 5'b11100};
            "9": {lk_len, lk_pat} = {3'd5, 5'b11110};
            default: {lk_len, lk_pat} = {3'd0, 5'b00000};
        endcase
    end

    // Last unit index of the current interval; code[4] is the element being keyed.
    always_comb begin
        case (state)
            MARK:    unit_last = code[4] ? 3'd2 : 3'd0;
            CGAP:    unit_last = 3'd2;
            WGAP:    unit_last = 3'd6;
            default: unit_last = 3'd0;
        endcase
    end

    always_comb begin
        state_d   = state;
        tick_d    = tick;
        unit_d    = unit;
        code_d    = code;
        remain_d  = remain;
        led_d     = o_led_n;
        err_d     = 1'b0;
        take      = i_valid && o_ready;
        tick_done = (tick == TICK_LAST);
        unit_done = tick_done && (unit == unit_last);

        if (state != IDLE) begin
            if (tick_done) begin
                tick_d = '0;
                unit_d = unit_done ? 3'd0 : unit + 3'd1;
            end else begin
                tick_d = tick + TW'(1);
            end
        end

        case (state)
            IDLE: begin
                if (take) begin
                    if (lk_len != 3'd0) begin
                        state_d  = MARK;
                        led_d    = 1'b0;
                        code_d   = lk_pat;
                        remain_d = lk_len - 3'd1;
                    end else if (upper == 8'h20) begin
                        state_d = WGAP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MARK: begin
                if (unit_done) begin
                    led_d = 1'b1;
                    if (remain != 3'd0) begin
                        state_d  = SPACE;
                        code_d   = {code[3:0], 1'b0};
                        remain_d = remain - 3'd1;
                    end else begin
                        state_d = CGAP;
                    end
                end
            end
            SPACE: begin
                if (unit_done) begin
                    state_d = MARK;
                    led_d   = 1'b0;
                end
            end
            CGAP, WGAP: begin
                if (unit_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            tick    <= '0;
            unit    <= 3'd0;
            code    <= 5'd0;
            remain  <= 3'd0;
            o_led_n <= 1'b1;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            state   <= state_d;
            tick    <= tick_d;
            unit    <= unit_d;
            code    <= code_d;
            remain  <= remain_d;
            o_led_n <= led_d;
            o_ready <= (state_d == IDLE);
            o_busy  <= (state_d != IDLE);
            o_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: vector table, multi-cycle corner sequences and random
// characters checked against a dot/dash string model of ITU Morse timing.
module tb_morse_encoder;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready, led_n, busy, err;

    int tests = 0;
    int fails = 0;

    logic [0:0] exp_q[$];
    logic [0:0] seq[$];

    string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                           ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                           "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string digits[10]  = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....",
                           "--...", "---..", "----."};

    typedef struct {
        logic [7:0] ch;
        logic       exp_err;
        int         period;
    } vec_t;

    vec_t vecs[12];

    morse_encoder #(.UNIT_TICKS(U)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_data (data),
        .i_valid(valid),
        .o_ready(ready),
        .o_led_n(led_n),
        .o_busy (busy),
        .o_err  (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic string morse_of(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A) return letters[c - 8'h41];
        if (c >= 8'h61 && c <= 8'h7A) return letters[c - 8'h61];
        if (c >= 8'h30 && c <= 8'h39) return digits[c - 8'h30];
        return "";
    endfunction

    // Expected LED level for every cycle from the transfer until the encoder is idle.
    function automatic void build_wave(input logic [7:0] c);
        string s;
        exp_q.delete();
        if (c == 8'h20) begin
            repeat (7 * U) exp_q.push_back(1'b1);
        end else begin
            s = morse_of(c);
            for (int i = 0; i < s.len(); i++) begin
                if (i > 0) repeat (U) exp_q.push_back(1'b1);
                repeat ((s[i] == 8'h2D) ? 3 * U : U) exp_q.push_back(1'b0);
            end
            if (s.len() > 0) repeat (3 * U) exp_q.push_back(1'b1);
        end
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", int'(ready), 1);
    endtask

    task automatic send_char(input logic [7:0] c, input logic exp_err, input int exp_period);
        int k;
        build_wave(c);
        wait_ready();
        data  = c;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        data  = 8'($urandom);
        check("err_pulse", int'(err), int'(exp_err));
        if (exp_err) begin
            check("err_ready", int'(ready), 1);
            check("err_led", int'(led_n), 1);
            @(negedge clk);
            check("err_one_cycle", int'(err), 0);
            check("err_led_after", int'(led_n), 1);
        end else begin
            k = 0;
            while (!ready && k < 400) begin
                check("led_wave", int'(led_n), (k < exp_q.size()) ? int'(exp_q[k]) : 1);
                check("busy_wave", int'(busy), 1);
                k++;
                @(negedge clk);
            end
            check("period", k, exp_period);
            check("led_idle", int'(led_n), 1);
            check("busy_idle", int'(busy), 0);
        end
    endtask

    initial begin
        string pool;
        logic [7:0] c;
        logic e;
        int p;

        vecs[0]  = '{8'h45, 1'b0, 16};   // E
        vecs[1]  = '{8'h61, 1'b0, 32};   // a
        vecs[2]  = '{8'h23, 1'b1, 0};    // #
        vecs[3]  = '{8'h20, 1'b0, 28};   // space
        vecs[4]  = '{8'h5A, 1'b0, 56};   // Z
        vecs[5]  = '{8'h35, 1'b0, 48};   // 5
        vecs[6]  = '{8'h71, 1'b0, 64};   // q
        vecs[7]  = '{8'h7E, 1'b1, 0};    // ~
        vecs[8]  = '{8'h39, 1'b0, 80};   // 9
        vecs[9]  = '{8'h6B, 1'b0, 48};   // k
        vecs[10] = '{8'h31, 1'b0, 80};   // 1
        vecs[11] = '{8'h48, 1'b0, 40};   // H

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_led", int'(led_n), 1);
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) send_char(vecs[i].ch, vecs[i].exp_err, vecs[i].period);

        // Back-to-back S then O with valid held; data swap while busy must not matter
        build_wave("S");
        seq = exp_q;
        seq.push_back(1'b1);
        build_wave("O");
        foreach (exp_q[i]) seq.push_back(exp_q[i]);
        wait_ready();
        data  = "S";
        valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < seq.size(); k++) begin
            check("b2b_led", int'(led_n), int'(seq[k]));
            if (k == 0) data = "O";
            if (k == 31) check("b2b_ready_low", int'(ready), 0);
            if (k == 32) check("b2b_ready_high", int'(ready), 1);
            if (k == 33) valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_end_ready", int'(ready), 1);
        check("b2b_end_led", int'(led_n), 1);

        // Reset during the second cycle of the first dash of '0'
        wait_ready();
        data  = "0";
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("rst_mid_led0", int'(led_n), 0);
        @(negedge clk);
        check("rst_mid_led1", int'(led_n), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_led", int'(led_n), 1);
        check("rst_mid_ready", int'(ready), 1);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_err", int'(err), 0);
        repeat (20) begin
            @(negedge clk);
            check("rst_mid_quiet_led", int'(led_n), 1);
            check("rst_mid_quiet_err", int'(err), 0);
        end
        send_char("T", 1'b0, 24);

        // Reset wins over a simultaneous transfer
        wait_ready();
        data  = "E";
        valid = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        rst   = 1'b0;
        repeat (5) begin
            check("rst_prio_led", int'(led_n), 1);
            check("rst_prio_ready", int'(ready), 1);
            @(negedge clk);
        end

        // Random characters against the model
        pool = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       c = 8'h20;
                1:       c = 8'($urandom_range(0, 255));
                default: c = pool[$urandom_range(0, pool.len() - 1)];
            endcase
            build_wave(c);
            e = (c != 8'h20) && (morse_of(c).len() == 0);
            p = exp_q.size();
            send_char(c, e, p);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
